// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and funct3 codes for the memory port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } req_id_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size code 11 has no RV32I meaning, so it is trapped like a misaligned access.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one RV32I memory between fetch
//                and load/store, with misaligned-access trapping.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misaligned,
    output logic              mem_write_mem,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [31:0]       mem_write_data,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [31:0]       mem_read_data
);

    arb_state_t        state_q, state_d;
    req_id_t           rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              err_q, err_d;

    logic w_idle;
    logic w_if_win;
    logic w_d_win;
    logic w_d_mis;

    assign w_idle   = (state_q == IDLE);
    assign w_if_win = w_idle && if_req && (!d_req || rr_last_q == DATA);
    assign w_d_win  = w_idle && d_req && (!if_req || rr_last_q == FETCH);
    assign w_d_mis  = is_misaligned(d_funct3, d_addr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_last_q <= DATA;
            addr_q    <= '0;
            f3_q      <= F3_W;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (w_if_win) begin
                    state_d   = RD_IF;
                    rr_last_d = FETCH;
                    addr_d    = if_addr;
                    f3_d      = F3_W;
                    err_d     = 1'b0;
                end else if (w_d_win) begin
                    rr_last_d = DATA;
                    if (!d_we) begin
                        state_d = RD_D;
                        err_d   = w_d_mis;
                        addr_d  = w_d_mis ? '0 : d_addr;
                        f3_d    = w_d_mis ? F3_W : d_funct3;
                    end
                end
            end
            RD_IF, RD_D: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt            = 1'b0;
        if_rvalid         = 1'b0;
        if_rdata          = '0;
        d_gnt             = 1'b0;
        d_rvalid          = 1'b0;
        d_rdata           = '0;
        d_misaligned      = 1'b0;
        mem_write_mem     = 1'b0;
        mem_funct3        = F3_W;
        mem_write_address = '0;
        mem_write_data    = '0;
        mem_read_address  = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (w_if_win) begin
                        if_gnt           = 1'b1;
                        mem_read_address = if_addr;
                    end else if (w_d_win) begin
                        d_gnt = 1'b1;
                        if (w_d_mis) begin
                            d_misaligned = d_we;
                        end else if (d_we) begin
                            mem_write_mem     = 1'b1;
                            mem_write_address = d_addr;
                            mem_write_data    = d_wdata;
                            mem_funct3        = d_funct3;
                        end else begin
                            mem_read_address = d_addr;
                            mem_funct3       = d_funct3;
                        end
                    end
                end
                // Hold the captured address/width so the memory re-reads the same lanes.
                RD_IF: begin
                    if_rvalid        = 1'b1;
                    if_rdata         = mem_read_data;
                    mem_read_address = addr_q;
                    mem_funct3       = f3_q;
                end
                RD_D: begin
                    d_rvalid         = 1'b1;
                    d_misaligned     = err_q;
                    d_rdata          = err_q ? 32'd0 : mem_read_data;
                    mem_read_address = addr_q;
                    mem_funct3       = f3_q;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench with a byte-addressed memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_misaligned;
    logic [31:0] d_rdata;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address;
    logic [31:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_gnt            (if_gnt),
        .if_rvalid         (if_rvalid),
        .if_rdata          (if_rdata),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_funct3          (d_funct3),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_gnt             (d_gnt),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata),
        .d_misaligned      (d_misaligned),
        .mem_write_mem     (mem_write_mem),
        .mem_funct3        (mem_funct3),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
    );

    // Memory model: registered, extended read; read port frozen during writes.
    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        logic [31:0] r;
        b0 = mem[a[11:0]];
        b1 = mem[a[11:0] + 12'd1];
        b2 = mem[a[11:0] + 12'd2];
        b3 = mem[a[11:0] + 12'd3];
        case (f3)
            3'b000:  r = {{24{b0[7]}}, b0};
            3'b001:  r = {{16{b1[7]}}, b1, b0};
            3'b100:  r = {24'd0, b0};
            3'b101:  r = {16'd0, b1, b0};
            default: r = {b3, b2, b1, b0};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_write_mem) begin
            mem[mem_write_address[11:0]] <= mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_write_address[11:0] + 12'd1] <= mem_write_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_write_address[11:0] + 12'd2] <= mem_write_data[23:16];
                mem[mem_write_address[11:0] + 12'd3] <= mem_write_data[31:24];
            end
        end else begin
            mem_read_data <= mem_rd(mem_read_address, mem_funct3);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = '0; d_wdata = '0;
    endtask

    task automatic set_d(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp_seq [0:7];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        {mem[19], mem[18], mem[17], mem[16]} = 32'h00500093;
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b0001;
        exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0010; exp_seq[6] = 4'b0100; exp_seq[7] = 4'b0001;
        reset = 1'b1;
        idle_inputs();

        // Reset: request held during reset must not be granted
        tick(); tick();
        if_req = 1'b1; if_addr = 32'h10;
        settle();
        check_eq("rst_outs", {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        check_eq("rst_wmem", {31'd0, mem_write_mem}, 32'd0);

        // Fetch only
        tick(); reset = 1'b0;
        settle();
        check_eq("f_gnt0", {31'd0, if_gnt}, 32'd1);
        check_eq("f_raddr0", mem_read_address, 32'h10);
        check_eq("f_f3_0", {29'd0, mem_funct3}, 32'd2);
        tick(); settle();
        check_eq("f_gnt1", {31'd0, if_gnt}, 32'd0);
        check_eq("f_rvalid1", {31'd0, if_rvalid}, 32'd1);
        check_eq("f_rdata1", if_rdata, 32'h00500093);
        tick(); settle();
        check_eq("f_gnt2", {31'd0, if_gnt}, 32'd1);
        tick(); if_req = 1'b0; settle();
        check_eq("f_rvalid3", {31'd0, if_rvalid}, 32'd1);

        // Both requesting continuously from reset
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        set_d(1'b0, 3'b010, 32'h10, 32'd0);
        settle();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin tick(); settle(); end
            check_eq($sformatf("rr_c%0d", c), {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid},
                     {28'd0, exp_seq[c]});
            if (c == 3) check_eq("rr_drdata", d_rdata, 32'h00500093);
        end
        tick(); idle_inputs(); settle();

        // Store byte then lbu / lb
        set_d(1'b1, 3'b000, 32'h101, 32'h123456A5);
        settle();
        check_eq("sb_gnt", {30'd0, d_gnt, mem_write_mem}, 32'd3);
        check_eq("sb_waddr", mem_write_address, 32'h101);
        check_eq("sb_wdata", mem_write_data, 32'h123456A5);
        tick(); set_d(1'b0, 3'b100, 32'h101, 32'd0); settle();
        check_eq("lbu_gnt", {30'd0, d_gnt, mem_write_mem}, 32'd2);
        tick(); idle_inputs(); settle();
        check_eq("lbu_rv", {31'd0, d_rvalid}, 32'd1);
        check_eq("lbu_data", d_rdata, 32'h000000A5);
        tick(); set_d(1'b0, 3'b000, 32'h101, 32'd0); settle();
        tick(); idle_inputs(); settle();
        check_eq("lb_data", d_rdata, 32'hFFFFFFA5);

        // Misaligned lw at 0x102
        tick(); set_d(1'b0, 3'b010, 32'h102, 32'd0); settle();
        check_eq("mlw_gnt", {29'd0, d_gnt, d_misaligned, mem_write_mem}, 32'd4);
        check_eq("mlw_raddr", mem_read_address, 32'd0);
        tick(); idle_inputs(); settle();
        check_eq("mlw_rv", {30'd0, d_rvalid, d_misaligned}, 32'd3);
        check_eq("mlw_data", d_rdata, 32'd0);

        // Misaligned sh at 0x103
        tick(); set_d(1'b1, 3'b001, 32'h103, 32'h0000BEEF); settle();
        check_eq("msh_gnt", {29'd0, d_gnt, d_misaligned, mem_write_mem}, 32'd6);
        tick(); set_d(1'b0, 3'b010, 32'h100, 32'd0); settle();
        tick(); idle_inputs(); settle();
        check_eq("msh_mem", d_rdata, 32'h0000A500);

        // Back-to-back stores then read-back
        for (int k = 0; k < 3; k++) begin
            tick();
            set_d(1'b1, 3'b010, 32'h200 + 32'(4 * k), 32'hCAFE0000 + 32'(k));
            settle();
            check_eq($sformatf("sw_gnt%0d", k), {30'd0, d_gnt, mem_write_mem}, 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            tick(); set_d(1'b0, 3'b010, 32'h200 + 32'(4 * k), 32'd0); settle();
            tick(); idle_inputs(); settle();
            check_eq($sformatf("lw_rd%0d", k), d_rdata, 32'hCAFE0000 + 32'(k));
        end

        // Reset during RD_D
        tick(); set_d(1'b0, 3'b010, 32'h200, 32'd0); settle();
        check_eq("rrd_gnt", {31'd0, d_gnt}, 32'd1);
        tick(); idle_inputs(); reset = 1'b1; settle();
        check_eq("rrd_rv", {31'd0, d_rvalid}, 32'd0);
        tick(); reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        set_d(1'b0, 3'b010, 32'h200, 32'd0);
        settle();
        check_eq("rrd_tie", {30'd0, if_gnt, d_gnt}, 32'd2);
        tick(); idle_inputs(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port RV32I memory (one registered read port with 1-cycle latency, one write port, reads frozen while write_mem is high) between two requesters: instruction fetch and load/store data.
- Arbitrates between them with a round-robin policy.
- Sequences each access into the memory's command signals and returns read data with a valid strobe.
- Traps misaligned data accesses before they reach memory.
- Sits between the processor core and memory; drives every memory input except clk.

Parameters:
- ADDR_W, 32, byte-address width of both requesters and of the memory.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address; word-aligned by contract
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle strobe: if_rdata valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held with its fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle strobe: load data (or error) valid
- d_rdata  out  32  load data, already extended by memory
- d_misaligned  out  1  with d_rvalid (load) or in grant cycle (store): access was misaligned and suppressed
- mem_write_mem  out  1  to memory write_mem
- mem_funct3  out  3  to memory funct3
- mem_write_address  out  32  to memory write_address
- mem_write_data  out  32  to memory write_data
- mem_read_address  out  32  to memory read_address
- mem_read_data  in  32  from memory read_data

Behaviour:
- States: IDLE, RD_IF, RD_D. Reset forces IDLE and rr_last=DATA, so fetch wins the first tie.
- Outputs are 0 during reset and in any cycle they are not asserted: gnt, rvalid, misaligned, rdata, mem_write_mem.
- IDLE arbitration:
  - Only one requester active: it wins.
  - Both active: the one not equal to rr_last wins.
  - rr_last updates to the winner on every grant.
- The winner's gnt is combinational in IDLE, in the same cycle as the request.
- Fetch grant:
  - mem_read_address=if_addr, mem_funct3=010, mem_write_mem=0.
  - Next state RD_IF.
- Data load grant, aligned:
  - mem_read_address=d_addr, mem_funct3=d_funct3, mem_write_mem=0.
  - Next state RD_D.
- Data store grant, aligned:
  - mem_write_mem=1, mem_write_address=d_addr, mem_write_data=d_wdata, mem_funct3=d_funct3.
  - Stay IDLE. No rvalid; the store completes at that clock edge.
- Misalignment rule:
  - Halfword (funct3[1:0]=01) is misaligned when addr[0]=1.
  - Word (funct3[1:0]=10) is misaligned when addr[1:0]≠0.
  - funct3[1:0]=11 is treated as misaligned.
- Misaligned store: d_gnt=1 and d_misaligned=1 in the grant cycle; mem_write_mem stays 0; stay IDLE.
- Misaligned load: d_gnt=1; no memory access issued. Next state RD_D with a registered error flag; in RD_D, d_rvalid=1, d_misaligned=1, d_rdata=0.
- RD_IF: if_rvalid=1, if_rdata=mem_read_data (memory's 1-cycle latency), mem_write_mem=0; next state IDLE.
- RD_D (no error): d_rvalid=1, d_rdata=mem_read_data; next state IDLE.
- No grants in RD_* states. Throughput is one read per 2 cycles and one store per cycle.
- In RD_* states, mem_read_address and mem_funct3 keep the granted values (registered copy), so the memory's captured byte lanes stay consistent.
- IDLE with no grant: mem_read_address=0, mem_funct3=010.
- Starvation: under continuous dual requests, grants strictly alternate.
- Reset mid-RD_*: the pending rvalid is dropped. The requester re-issues; it is not guaranteed a response.
- A request deasserted before grant is not an error; no state is kept for it.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, RD_IF, RD_D};
  - requester enum req_id_t {FETCH, DATA};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- No sub-module; the 2-way picker and alignment check are inline.

Test Plan:
- Fetch only: if_req, if_addr=0x10 with mem[4]=0x00500093 -> if_gnt in cycle 0; if_rvalid in cycle 1 with if_rdata=0x00500093; next grant no earlier than cycle 2.
- Both requesting from reset, continuously: grants go FETCH, DATA, FETCH, DATA on cycles 0,2,4,6; each rvalid comes one cycle after its grant.
- Store then load: sb 0xA5 to 0x101, then lbu/lb at 0x101 -> mem_write_mem=1 for exactly one cycle; d_rdata=0x000000A5 for lbu, 0xFFFFFFA5 for lb.
- Misaligned: lw at 0x102 -> d_gnt, then d_rvalid with d_misaligned=1, d_rdata=0, and no memory read issued. sh at 0x103 -> d_misaligned in the grant cycle and memory unchanged.
- Store-only stream: 3 back-to-back sw to 0x200/0x204/0x208 -> d_gnt on 3 consecutive cycles; later lw reads return the written values.
- Reset asserted during RD_D -> no d_rvalid; state IDLE next cycle; first post-reset tie grants FETCH.
